// File: rtl/display_pkg.sv
// Shared timing constants, data types and host FSM encoding for the display
// memory arbiter (optional host gating macro: HOST_VBLANK_ONLY_EN).
package display_pkg;

   localparam int unsigned HA_END = 639;
   localparam int unsigned LINE   = 799;
   localparam int unsigned VA_END = 479;
   localparam int unsigned SCREEN = 524;
   localparam int unsigned PIX_W  = 8;
   localparam int unsigned PPW    = 4;
   localparam int unsigned PPW_LG = $clog2(PPW);
   localparam int unsigned H_ACT  = HA_END + 1;
   localparam int unsigned WPL    = H_ACT / PPW;
   localparam int unsigned ADDR_W = 17;
   localparam int unsigned WORD_W = PIX_W * PPW;

   typedef logic [PIX_W-1:0]  pix_t;
   typedef logic [WORD_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {H_IDLE, H_RD, H_ACK} host_state_e;

endpackage

// File: rtl/display_fetch_sched.sv
// Display fetch scheduler: marks the cycles owned by scan-out reads and keeps
// fa, the address of the most recent display fetch.
module display_fetch_sched
   import display_pkg::*;
(
   input  logic              clk_pix,
   input  logic              rst_n,
   input  logic [9:0]        sx,
   input  logic [9:0]        sy,
   output logic              slot,
   output logic [ADDR_W-1:0] fetch_addr,
   output logic [ADDR_W-1:0] fa
);

   logic [10:0] sx2;
   logic [10:0] nn;
   logic [9:0]  line_nn;
   logic        wrap;
   logic        first;
   addr_t       fa_q;

   // Look two pixels ahead: one cycle of SRAM latency plus one to register the word.
   always_comb begin
      sx2     = {1'b0, sx} + 11'd2;
      wrap    = (sx2 > 11'(LINE));
      nn      = wrap ? (sx2 - 11'(LINE + 1)) : sx2;
      line_nn = sy;
      if (wrap) begin
         line_nn = (sy == 10'(SCREEN)) ? 10'd0 : (sy + 10'd1);
      end
      first      = (line_nn == 10'd0) && (nn == 11'd0);
      slot       = rst_n && (nn[PPW_LG-1:0] == '0) && (nn < 11'(WPL * PPW)) &&
                   (line_nn <= 10'(VA_END));
      fetch_addr = first ? '0 : (fa_q + addr_t'(1));
   end

   always_ff @(posedge clk_pix) begin
      if (!rst_n) begin
         fa_q <= '0;
      end else if (slot) begin
         fa_q <= fetch_addr;
      end
   end

   assign fa = fa_q;

endmodule

// File: rtl/display_mem_arbiter.sv
// Shares one single-port framebuffer SRAM between display scan-out and a host
// req/ack port. Define HOST_VBLANK_ONLY_EN to restrict host access to vblank.
module display_mem_arbiter
   import display_pkg::*;
(
   input  logic              clk_pix,
   input  logic              rst_n,
   input  logic [9:0]        sx,
   input  logic [9:0]        sy,
   input  logic              de,
   output logic [PIX_W-1:0]  pix,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [WORD_W-1:0] host_wdata,
   output logic              host_ack,
   output logic [WORD_W-1:0] host_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata
);

   logic        slot;
   addr_t       fetch_addr;
   addr_t       fa;
   host_state_e state_q;
   host_state_e state_d;
   logic        host_ok;
   logic        issue;
   logic        disp_rd_q;
   word_t       pix_word_q;
   word_t       host_rdata_q;

   display_fetch_sched u_sched (
      .clk_pix    (clk_pix),
      .rst_n      (rst_n),
      .sx         (sx),
      .sy         (sy),
      .slot       (slot),
      .fetch_addr (fetch_addr),
      .fa         (fa)
   );

`ifdef HOST_VBLANK_ONLY_EN
   assign host_ok = (sy > 10'(VA_END));
`else
   assign host_ok = 1'b1;
`endif

   // slot is already suppressed during reset; a display slot always blocks the host.
   assign issue = rst_n && host_ok && !slot && host_req && (state_q == H_IDLE);

   always_ff @(posedge clk_pix) begin
      if (!rst_n) begin
         state_q <= H_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         H_IDLE: begin
            if (issue) begin
               state_d = host_we ? H_ACK : H_RD;
            end
         end
         H_RD:    state_d = H_ACK;
         H_ACK:   state_d = H_IDLE;
         default: state_d = H_IDLE;
      endcase
   end

   always_comb begin
      host_ack = (state_q == H_ACK);
      mem_addr = fa;
      mem_we   = 1'b0;
      if (slot) begin
         mem_addr = fetch_addr;
      end else if (issue) begin
         mem_addr = host_addr;
         mem_we   = host_we;
      end
   end

   assign mem_wdata = host_wdata;

   // Read data returns the cycle after issue; disp_rd_q marks whose read it was.
   always_ff @(posedge clk_pix) begin
      if (!rst_n) begin
         disp_rd_q    <= 1'b0;
         pix_word_q   <= '0;
         host_rdata_q <= '0;
      end else begin
         disp_rd_q <= slot;
         if (disp_rd_q) begin
            pix_word_q <= mem_rdata;
         end
         if (state_q == H_RD) begin
            host_rdata_q <= mem_rdata;
         end
      end
   end

   assign host_rdata = host_rdata_q;

   always_comb begin
      pix = '0;
      if (de) begin
         pix = pix_word_q[sx[PPW_LG-1:0]*PIX_W +: PIX_W];
      end
   end

endmodule

// File: tb/tb_display_mem_arbiter.sv
// Directed bench for display_mem_arbiter with a behavioural one-cycle SRAM;
// the bench drives sx/sy itself and may jump between screen positions.
module tb_display_mem_arbiter;
   import display_pkg::*;

   logic        clk_pix = 1'b0;
   logic        rst_n;
   logic [9:0]  sx;
   logic [9:0]  sy;
   logic        de;
   logic [7:0]  pix;
   logic        host_req;
   logic        host_we;
   logic [16:0] host_addr;
   logic [31:0] host_wdata;
   logic        host_ack;
   logic [31:0] host_rdata;
   logic [16:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:131071];
   logic        mem_init = 1'b0;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk_pix = ~clk_pix;

   display_mem_arbiter dut (
      .clk_pix    (clk_pix),
      .rst_n      (rst_n),
      .sx         (sx),
      .sy         (sy),
      .de         (de),
      .pix        (pix),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_ack   (host_ack),
      .host_rdata (host_rdata),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always @(posedge clk_pix) begin
      if (!mem_init) begin
         mem[0]   <= 32'h4433_2211;
         mem[160] <= 32'hDDCC_BBAA;
         mem[161] <= 32'h0403_0201;
         mem[162] <= 32'h0807_0605;
         mem_init <= 1'b1;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic upd_de();
      de = (sx <= 10'd639) && (sy <= 10'd479);
   endtask

   task automatic step();
      @(posedge clk_pix);
      #1;
      if (sx == 10'd799) begin
         sx = 10'd0;
         sy = (sy == 10'd524) ? 10'd0 : (sy + 10'd1);
      end else begin
         sx = sx + 10'd1;
      end
      upd_de();
      #1;
   endtask

   task automatic jump(input int x, input int y);
      @(posedge clk_pix);
      #1;
      sx = 10'(x);
      sy = 10'(y);
      upd_de();
      #1;
   endtask

   task automatic host_set(input logic req, input logic we, input int addr, input logic [31:0] d);
      host_req   = req;
      host_we    = we;
      host_addr  = 17'(addr);
      host_wdata = d;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      sx    = 10'd0;
      sy    = 10'd0;
      upd_de();
      host_set(1'b1, 1'b1, 3, 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      repeat (3) @(posedge clk_pix);
      #1;
      rst_n = 1'b1;
      host_set(1'b0, 1'b0, 0, 32'h0);

      // Reset values, first fetch of line 0 at sx=2
      chk("rst_ack", 32'(host_ack), 32'h0);
      chk("rst_pix", 32'(pix), 32'h0);
      chk("rst_rdata", host_rdata, 32'h0);
      chk("rst_fsm", 32'(dut.state_q), 32'(H_IDLE));
      step();
      step();
      chk("first_fetch_addr", 32'(mem_addr), 32'd1);
      chk("first_fetch_we", 32'(mem_we), 32'h0);

      // Line 0 word 0 is fetched at the end of the previous frame
      jump(796, 524);
      step();
      step();
      chk("w0_fetch_addr", 32'(mem_addr), 32'd0);
      step();
      chk("blank_pix", 32'(pix), 32'h0);
      step();
      chk("l0_pix0", 32'(pix), 32'h11);
      step();
      chk("l0_pix1", 32'(pix), 32'h22);
      step();
      chk("l0_pix2", 32'(pix), 32'h33);
      step();
      chk("l0_pix3", 32'(pix), 32'h44);
      repeat (797) step();
      chk("l1_pix0", 32'(pix), 32'hAA);
      step();
      chk("l1_pix1", 32'(pix), 32'hBB);

      // Line 10: host read collides with the sx=2 display slot
      jump(797, 9);
      step();
      chk("l10_w0_addr", 32'(mem_addr), 32'd161);
      step();
      step();
      chk("l10_pix0", 32'(pix), 32'h01);
      step();
      step();
`ifndef HOST_VBLANK_ONLY_EN
      host_set(1'b1, 1'b0, 161, 32'h0);
      chk("conflict_addr", 32'(mem_addr), 32'd162);
      chk("conflict_we", 32'(mem_we), 32'h0);
      step();
      chk("host_issue_addr", 32'(mem_addr), 32'd161);
      chk("l10_pix3", 32'(pix), 32'h04);
      step();
      chk("h_rd_ack", 32'(host_ack), 32'h0);
      chk("l10_pix4", 32'(pix), 32'h05);
      step();
      chk("conflict_ack", 32'(host_ack), 32'h1);
      chk("conflict_rdata", host_rdata, 32'h0403_0201);
      chk("l10_pix5", 32'(pix), 32'h06);
      host_set(1'b0, 1'b0, 0, 32'h0);
      step();
      chk("ack_pulse", 32'(host_ack), 32'h0);
      chk("l10_pix6", 32'(pix), 32'h07);
`else
      step();
      step();
      chk("l10_pix4", 32'(pix), 32'h05);
`endif

      // Vblank write then read of the same word
      jump(100, 500);
      host_set(1'b1, 1'b1, 5, 32'hDEAD_BEEF);
      chk("wr_we", 32'(mem_we), 32'h1);
      chk("wr_addr", 32'(mem_addr), 32'd5);
      chk("wr_data", mem_wdata, 32'hDEAD_BEEF);
      chk("wr_ack_t0", 32'(host_ack), 32'h0);
      step();
      chk("wr_ack_t1", 32'(host_ack), 32'h1);
      host_set(1'b0, 1'b0, 0, 32'h0);
      step();
      chk("wr_ack_t2", 32'(host_ack), 32'h0);
      host_set(1'b1, 1'b0, 5, 32'h0);
      chk("rd_addr", 32'(mem_addr), 32'd5);
      chk("rd_we", 32'(mem_we), 32'h0);
      step();
      chk("rd_ack_t1", 32'(host_ack), 32'h0);
      step();
      chk("rd_ack_t2", 32'(host_ack), 32'h1);
      chk("rd_data", host_rdata, 32'hDEAD_BEEF);
      host_set(1'b0, 1'b0, 0, 32'h0);
      step();

      // Reset in the middle of a host read
      host_set(1'b1, 1'b0, 5, 32'h0);
      chk("abort_issue", 32'(mem_addr), 32'd5);
      step();
      rst_n = 1'b0;
      #1;
      chk("abort_rst_we", 32'(mem_we), 32'h0);
      chk("abort_rst_ack", 32'(host_ack), 32'h0);
      step();
      rst_n = 1'b1;
      host_set(1'b0, 1'b0, 0, 32'h0);
      chk("abort_ack", 32'(host_ack), 32'h0);
      chk("abort_fsm", 32'(dut.state_q), 32'(H_IDLE));
      chk("abort_fa", 32'(mem_addr), 32'd0);
      chk("abort_rdata", host_rdata, 32'h0);
      step();
      chk("abort_ack2", 32'(host_ack), 32'h0);

      // Host request during active video
      jump(700, 100);
      host_set(1'b1, 1'b1, 7, 32'h1234_5678);
`ifndef HOST_VBLANK_ONLY_EN
      chk("active_we", 32'(mem_we), 32'h1);
      chk("active_addr", 32'(mem_addr), 32'd7);
      step();
      chk("active_ack", 32'(host_ack), 32'h1);
      host_set(1'b0, 1'b0, 0, 32'h0);
      step();
`else
      chk("active_hold_we", 32'(mem_we), 32'h0);
      step();
      chk("active_hold_ack", 32'(host_ack), 32'h0);
      jump(799, 479);
      chk("last_line_we", 32'(mem_we), 32'h0);
      step();
      chk("vblank_we", 32'(mem_we), 32'h1);
      chk("vblank_addr", 32'(mem_addr), 32'd7);
      step();
      chk("vblank_ack", 32'(host_ack), 32'h1);
      host_set(1'b0, 1'b0, 0, 32'h0);
      // Frame-wrap fetch still beats a vblank host request
      jump(798, 524);
      host_set(1'b1, 1'b0, 9, 32'h0);
      chk("wrap_slot_addr", 32'(mem_addr), 32'd0);
      chk("wrap_slot_we", 32'(mem_we), 32'h0);
      step();
      chk("wrap_host_addr", 32'(mem_addr), 32'd9);
      host_set(1'b0, 1'b0, 0, 32'h0);
      step();
      step();
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
